// File: rtl/code_sweep_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_sweep_pkg : shared types, mode codes and mask-walking helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package code_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_XS3  = 2'd2;
  localparam logic [1:0] MODE_BCD  = 2'd3;
  localparam int         NMODES    = 4;

  function automatic logic [1:0] first_set(input logic [NMODES-1:0] mask);
    logic [1:0] r;
    r = '0;
    for (int i = NMODES - 1; i >= 0; i--)
      if (mask[i]) r = 2'(i);
    return r;
  endfunction

  // Returns idx itself when no enabled mode lies above it.
  function automatic logic [1:0] next_set(input logic [NMODES-1:0] mask,
                                          input logic [1:0]        idx);
    logic [1:0] r;
    r = idx;
    for (int i = NMODES - 1; i >= 0; i--)
      if (mask[i] && (i > int'(idx))) r = 2'(i);
    return r;
  endfunction

  function automatic logic verdicts_agree(input logic [NMODES-1:0] mask,
                                          input logic [NMODES-1:0] gt,
                                          input logic [NMODES-1:0] lt,
                                          input logic [NMODES-1:0] eq);
    logic [1:0] f;
    logic       ok;
    f  = first_set(mask);
    ok = 1'b1;
    for (int i = 0; i < NMODES; i++)
      if (mask[i] && ({gt[i], lt[i], eq[i]} != {gt[f], lt[f], eq[f]})) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_code_system.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_code_system : 4-bit code converter and magnitude comparator
// Rev 1.0
// ---------------------------------------------------------------------------
module multi_code_system
  import code_sweep_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] conv_a,
  output logic [3:0] conv_b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  function automatic logic [3:0] convert(input logic [1:0] m, input logic [3:0] v);
    logic [3:0] r;
    case (m)
      MODE_GRAY: r = v ^ (v >> 1);
      MODE_XS3:  r = v + 4'd3;
      MODE_BCD:  r = (v > 4'd9) ? 4'd9 : v;
      default:   r = v;
    endcase
    return r;
  endfunction

  assign conv_a = convert(mode, a);
  assign conv_b = convert(mode, b);
  assign gt     = conv_a > conv_b;
  assign lt     = conv_a < conv_b;
  assign eq     = conv_a == conv_b;

endmodule
`default_nettype wire

// File: rtl/code_sweep_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_sweep_sequencer : sweeps one operand pair through all enabled modes
// Rev 1.0
// ---------------------------------------------------------------------------
module code_sweep_sequencer
  import code_sweep_pkg::*;
#(
  parameter logic [3:0] MODE_MASK = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  cmp_gt,
  output logic [3:0]  cmp_lt,
  output logic [3:0]  cmp_eq,
  output logic [15:0] conv_a,
  output logic [15:0] conv_b,
  output logic        agree
);

  state_e      state_q, state_d;
  logic [1:0]  mode_idx_q, mode_idx_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic [3:0]  gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [15:0] conv_a_q, conv_a_d, conv_b_q, conv_b_d;
  logic        agree_q, agree_d;

  logic [3:0]  mcs_conv_a, mcs_conv_b;
  logic        mcs_gt, mcs_lt, mcs_eq;

  multi_code_system u_mcs (
    .mode   (mode_idx_q),
    .a      (a_q),
    .b      (b_q),
    .conv_a (mcs_conv_a),
    .conv_b (mcs_conv_b),
    .gt     (mcs_gt),
    .lt     (mcs_lt),
    .eq     (mcs_eq)
  );

  always_comb begin
    state_d    = state_q;
    mode_idx_d = mode_idx_q;
    a_d        = a_q;
    b_d        = b_q;
    gt_d       = gt_q;
    lt_d       = lt_q;
    eq_d       = eq_q;
    conv_a_d   = conv_a_q;
    conv_b_d   = conv_b_q;
    agree_d    = agree_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          gt_d       = '0;
          lt_d       = '0;
          eq_d       = '0;
          conv_a_d   = '0;
          conv_b_d   = '0;
          agree_d    = 1'b0;
          mode_idx_d = first_set(MODE_MASK);
          state_d    = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        gt_d[mode_idx_q]                 = mcs_gt;
        lt_d[mode_idx_q]                 = mcs_lt;
        eq_d[mode_idx_q]                 = mcs_eq;
        conv_a_d[{mode_idx_q, 2'b00} +: 4] = mcs_conv_a;
        conv_b_d[{mode_idx_q, 2'b00} +: 4] = mcs_conv_b;
        // next_set returning the same index marks the last enabled mode
        if (next_set(MODE_MASK, mode_idx_q) == mode_idx_q) begin
          state_d = ST_DONE;
          agree_d = verdicts_agree(MODE_MASK, gt_d, lt_d, eq_d);
        end else begin
          mode_idx_d = next_set(MODE_MASK, mode_idx_q);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      gt_q       <= '0;
      lt_q       <= '0;
      eq_q       <= '0;
      conv_a_q   <= '0;
      conv_b_q   <= '0;
      agree_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_idx_q <= mode_idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      eq_q       <= eq_d;
      conv_a_q   <= conv_a_d;
      conv_b_q   <= conv_b_d;
      agree_q    <= agree_d;
    end
  end

  always @(posedge clk) begin
    assert (MODE_MASK != 4'b0000) else $error("MODE_MASK must enable at least one mode");
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign cmp_gt    = gt_q;
  assign cmp_lt    = lt_q;
  assign cmp_eq    = eq_q;
  assign conv_a    = conv_a_q;
  assign conv_b    = conv_b_q;
  assign agree     = agree_q;

endmodule
`default_nettype wire

// File: tb/tb_code_sweep_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_code_sweep_sequencer : directed bench, default mask and mask 4'b0101
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_code_sweep_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, agree;
  logic [3:0]  a, b, cmp_gt, cmp_lt, cmp_eq;
  logic [15:0] conv_a, conv_b;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_agree;
  logic [3:0]  m_a, m_b, m_cmp_gt, m_cmp_lt, m_cmp_eq;
  logic [15:0] m_conv_a, m_conv_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  code_sweep_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .conv_a(conv_a), .conv_b(conv_b), .agree(agree)
  );

  code_sweep_sequencer #(.MODE_MASK(4'b0101)) dut_m (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .cmp_gt(m_cmp_gt), .cmp_lt(m_cmp_lt), .cmp_eq(m_cmp_eq),
    .conv_a(m_conv_a), .conv_b(m_conv_b), .agree(m_agree)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] va, input logic [3:0] vb);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic expect_result(input string tag, input logic [3:0] gt, input logic [3:0] lt,
                               input logic [3:0] eq, input logic [15:0] ca,
                               input logic [15:0] cb, input logic ag);
    check({tag, "_gt"},    32'(cmp_gt), 32'(gt));
    check({tag, "_lt"},    32'(cmp_lt), 32'(lt));
    check({tag, "_eq"},    32'(cmp_eq), 32'(eq));
    check({tag, "_conva"}, 32'(conv_a), 32'(ca));
    check({tag, "_convb"}, 32'(conv_b), 32'(cb));
    check({tag, "_agree"}, 32'(agree),  32'(ag));
  endtask

  task automatic release_done(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_iready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic seen_valid;
    int   k;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = '0; m_b = '0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_results",   {cmp_gt, cmp_lt, cmp_eq, 3'b000, agree}, 32'd0);
    check("rst_conv",      {conv_a, conv_b}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    accept(4'd5, 4'd3);
    wait_valid("lat_5_3", 4);
    expect_result("p5_3", 4'b1111, 4'b0000, 4'b0000, 16'h5875, 16'h3623, 1'b1);
    release_done("p5_3");

    accept(4'd13, 4'd2);
    wait_valid("lat_13_2", 4);
    expect_result("p13_2", 4'b1011, 4'b0100, 4'b0000, 16'h90BD, 16'h2532, 1'b0);
    release_done("p13_2");

    accept(4'd7, 4'd7);
    wait_valid("lat_7_7", 4);
    expect_result("p7_7", 4'b0000, 4'b0000, 4'b1111, 16'h7A47, 16'h7A47, 1'b1);
    release_done("p7_7");

    // Backpressure: DONE held while the input side thrashes.
    accept(4'd12, 4'd10);
    wait_valid("lat_12_10", 4);
    expect_result("p12_10", 4'b0101, 4'b0010, 4'b1000, 16'h9FAC, 16'h9DFA, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      a = 4'(i);
      b = 4'(15 - i);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_hold_cmp",  {20'd0, cmp_gt, cmp_lt, cmp_eq}, 32'h528);
      check("bp_hold_conv", {conv_a, conv_b}, 32'h9FAC9DFA);
    end
    in_valid = 1'b0;
    release_done("bp");
    for (int i = 0; i < 6; i++) tick();
    check("bp_no_new_accept", 32'(out_valid), 32'd0);

    // Reset during the second sweep cycle discards the pair.
    accept(4'd5, 4'd3);
    tick();
    check("mid_partial_gt", 32'(cmp_gt), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_results", {cmp_gt, cmp_lt, cmp_eq, 3'b000, agree}, 32'd0);
    check("mid_rst_conv",    {conv_a, conv_b}, 32'd0);
    check("mid_rst_ovalid",  32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_iready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen_valid), 32'd0);

    // Sparse mask 4'b0101.
    k = 0;
    while (!m_in_ready && k < 20) begin
      tick();
      k++;
    end
    m_a = 4'd5;
    m_b = 4'd3;
    m_in_valid = 1'b1;
    tick();
    m_in_valid = 1'b0;
    k = 0;
    while (!m_out_valid && k < 20) begin
      tick();
      k++;
    end
    check("m_latency", 32'(k), 32'd2);
    check("m_gt",    32'(m_cmp_gt), 32'b0101);
    check("m_lt",    32'(m_cmp_lt), 32'd0);
    check("m_eq",    32'(m_cmp_eq), 32'd0);
    check("m_conva", 32'(m_conv_a), 32'h0805);
    check("m_convb", 32'(m_conv_b), 32'h0603);
    check("m_agree", 32'(m_agree),  32'd1);
    m_out_ready = 1'b1;
    tick();
    m_out_ready = 1'b0;
    check("m_back_idle", {30'd0, m_in_ready, m_out_valid}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_sweep_sequencer.md
# code_sweep_sequencer

Sequential front-end and result collector around the existing combinational `multi_code_system` converter/comparator. It accepts one operand pair (A, B) through a valid/ready handshake and steps the comparator through every enabled code mode, one mode per clock. It captures each mode's verdict and converted values into packed result registers, then presents the whole sweep downstream through a second valid/ready handshake. It is both the driver feeding `multi_code_system` and the consumer of its outputs.

## Interface
- `MODE_MASK`, default `4'b1111`: bit m = 1 enables sweep of mode m (0 binary, 1 Gray, 2 excess-3, 3 BCD-clamp). Must be nonzero; a simulation assertion enforces this.
- `clk  in  1`: the single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: operand pair on `a`/`b` is valid.
- `in_ready  out  1`: block can accept an operand pair.
- `a  in  4`: operand A, unsigned.
- `b  in  4`: operand B, unsigned.
- `out_valid  out  1`: sweep result is valid.
- `out_ready  in  1`: downstream consumes the result.
- `cmp_gt  out  4`: bit m = A>B in mode m.
- `cmp_lt  out  4`: bit m = A<B in mode m.
- `cmp_eq  out  4`: bit m = A==B in mode m.
- `conv_a  out  16`: nibble m (bits 4m+3:4m) = converted A in mode m.
- `conv_b  out  16`: nibble m = converted B in mode m.
- `agree  out  1`: all enabled modes gave the identical {gt,lt,eq} verdict.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch a/b, clear all result registers, set `mode_idx` = lowest set bit of MODE_MASK, go to SWEEP.
- SWEEP:
  - Comparator mode input = `mode_idx`; operands = latched A/B.
  - Each cycle, write comparator gt/lt/eq into bit `mode_idx` and convA/convB into nibble `mode_idx`.
  - If `mode_idx` is the highest set bit of MODE_MASK, go to DONE; otherwise advance to the next set bit.
- DONE:
  - `out_valid`=1; outputs held stable.
  - On `out_ready`, go to IDLE.
- Disabled modes: gt/lt/eq bits and conv nibbles are 0.
- `agree`: computed over enabled modes only; registered, valid whenever `out_valid`=1.
- Conversions stay 4-bit, exactly as in `multi_code_system`:
  - Gray: A^(A>>1).
  - Excess-3: wraps mod 16 (13+3 = 0).
  - BCD: values above 9 clamp to 9.
- `in_valid` is ignored outside IDLE; `in_ready` is 0 in SWEEP and DONE.

## Timing
- Reset values:
  - state IDLE; all result registers, `out_valid` and `agree` are 0.
  - `in_ready` is 0 while `rst` is high and 1 from the first cycle after release.
- Latency: the accept edge is edge 0. Sweep captures occur on edges 1..N (N = popcount(MODE_MASK)). `out_valid` rises after edge N.
- Throughput: minimum accept-to-accept interval is N+2 cycles (6 with the default mask and `out_ready` held high).
- Backpressure: with `out_ready` low, DONE holds indefinitely and all outputs stay constant.
- `rst` asserted in any state, including mid-SWEEP: next edge returns to IDLE with outputs at their reset values. The partial sweep is discarded and no `out_valid` pulse occurs.
- `out_ready` asserted outside DONE has no effect.

## Structure
- Package `code_sweep_pkg`:
  - state enum (IDLE/SWEEP/DONE);
  - mode constants MODE_BIN=0, MODE_GRAY=1, MODE_XS3=2, MODE_BCD=3, NMODES=4;
  - functions `first_set(mask)` and `next_set(mask, idx)`.
- One sub-module: an instance of the existing `multi_code_system`, fed by the latched operands and `mode_idx`. No conversion logic is duplicated in this block.

## Test plan
- Default mask, A=5, B=3 -> after 4 sweep cycles: `cmp_gt`=4'b1111, `cmp_lt`=0, `cmp_eq`=0, `conv_a`=16'h5875, `conv_b`=16'h3623, `agree`=1.
- A=13, B=2 -> `cmp_gt`=4'b1011, `cmp_lt`=4'b0100, `conv_a`=16'h90BD, `conv_b`=16'h2532, `agree`=0 (excess-3 wrap).
- A=12, B=10 -> `cmp_gt`=4'b0101, `cmp_lt`=4'b0010, `cmp_eq`=4'b1000, `agree`=0.
- MODE_MASK=4'b0101, A=5, B=3 -> `out_valid` 2 cycles after accept; `cmp_gt`=4'b0101, `conv_a`=16'h0805, `conv_b`=16'h0603.
- Hold `out_ready`=0 for 10 cycles in DONE while toggling `in_valid`/`a`/`b` -> outputs constant, `in_ready`=0, no new accept; release -> IDLE next cycle.
- Assert `rst` on the second SWEEP cycle -> next cycle IDLE, all outputs 0, `in_ready`=1, no `out_valid` ever seen for that pair.
